glyph_fetch: RTL

GLYPH_FETCH -- requirements
Module: glyph_fetch

---
 rtl/glyph_fetch_pkg.sv | 41 ++++
 rtl/glyph_fifo.sv | 60 ++++++
 rtl/glyph_fetch.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/glyph_fetch_pkg.sv
// glyph_fetch_pkg: slot constants, text geometry, FSM state type and address helpers
// shared by the glyph fetch engine and its FIFO.
`default_nettype none

package glyph_fetch_pkg;

  localparam int DATAWIDTH  = 16;
  localparam int TEXT_COLS  = 40;
  localparam int TEXT_ROWS  = 30;
  localparam int GLYPH_ROWS = 16;
  localparam int FIFO_WIDTH = DATAWIDTH + 8;

  localparam logic [2:0] VGA_CHAR_SLOT  = 3'd6;
  localparam logic [2:0] VGA_GLYPH_SLOT = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHAR  = 2'd1,
    GLYPH = 2'd2,
    STALL = 2'd3
  } fetch_state_t;

  function automatic logic [DATAWIDTH-1:0] f_char_addr(
    input logic [DATAWIDTH-1:0] base,
    input logic [4:0]           trow,
    input logic [5:0]           col
  );
    return base + (16'(trow) * 16'(TEXT_COLS)) + 16'(col);
  endfunction

  function automatic logic [DATAWIDTH-1:0] f_glyph_addr(
    input logic [DATAWIDTH-1:0] base,
    input logic [7:0]           code,
    input logic [3:0]           line
  );
    return base + {4'd0, code, 4'd0} + {12'd0, line};
  endfunction

endpackage

`default_nettype wire

// File: rtl/glyph_fifo.sv
// glyph_fifo: two-entry FIFO holding {glyph word, fg, bg} between fetch and shifter.
`default_nettype none

module glyph_fifo #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr;
  logic             r_rd;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == 2'd2);
  assign empty  = (r_count == 2'd0);
  assign rdata  = r_mem[r_rd];
  assign w_push = push && (!full || pop);
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_count  <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (flush) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= wdata;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/glyph_fetch.sv
// glyph_fetch: text-mode character/glyph fetch FSM, 2-entry FIFO and pixel shifter.
// Optional macro GLYPH_FETCH_UNDERRUN_EN enables the sticky underrun flag.
`default_nettype none

module glyph_fetch
  import glyph_fetch_pkg::*;
#(
  parameter logic [15:0] TEXT_BASE  = 16'hC000,
  parameter logic [15:0] GLYPH_BASE = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  acnt,
  input  logic [15:0] dmem,
  input  logic        line_start,
  input  logic [8:0]  vrow,
  input  logic        pix_en,
  input  logic        active,
  output logic [15:0] glyph_addr,
  output logic [3:0]  pix_color,
  output logic        underrun
);

  localparam logic [5:0] LAST_COL = 6'(TEXT_COLS - 1);

  fetch_state_t          r_state;
  logic [5:0]            r_col;
  logic [8:0]            r_vrow;
  logic [15:0]           r_char;
  logic [15:0]           r_glyph_addr;

  logic [15:0]           r_shift;
  logic [3:0]            r_bitcnt;
  logic [3:0]            r_fg;
  logic [3:0]            r_bg;
  logic                  r_valid;
  logic [3:0]            r_pix_color;

  logic                  w_push;
  logic                  w_load;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_full_after;
  logic [FIFO_WIDTH-1:0] w_head;
  logic [15:0]           w_head_word;

  assign w_push       = (r_state == GLYPH) && (acnt == VGA_GLYPH_SLOT) && !line_start;
  assign w_load       = pix_en && active && (r_bitcnt == 4'd0);
  assign w_pop        = w_load && !w_fifo_empty;
  // Push only happens with at most one entry queued, so full afterwards means one stays.
  assign w_full_after = !w_fifo_empty && !w_pop;
  assign w_head_word  = w_head[FIFO_WIDTH-1:8];

  glyph_fifo #(
    .WIDTH (FIFO_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (line_start),
    .push  (w_push),
    .wdata ({dmem, r_char[11:8], r_char[15:12]}),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // glyph_addr is registered alongside the state so it is already valid in the slot clock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_col        <= 6'd0;
      r_vrow       <= 9'd0;
      r_char       <= 16'd0;
      r_glyph_addr <= 16'd0;
    end else if (line_start) begin
      r_state      <= CHAR;
      r_vrow       <= vrow;
      r_col        <= 6'd0;
      r_glyph_addr <= f_char_addr(TEXT_BASE, vrow[8:4], 6'd0);
    end else begin
      case (r_state)
        CHAR: begin
          if (acnt == VGA_CHAR_SLOT) begin
            r_char       <= dmem;
            r_state      <= GLYPH;
            r_glyph_addr <= f_glyph_addr(GLYPH_BASE, dmem[7:0], r_vrow[3:0]);
          end
        end
        GLYPH: begin
          if (acnt == VGA_GLYPH_SLOT) begin
            r_col <= r_col + 6'd1;
            if (r_col == LAST_COL) begin
              r_state <= IDLE;
            end else if (w_full_after) begin
              r_state <= STALL;
            end else begin
              r_state      <= CHAR;
              r_glyph_addr <= f_char_addr(TEXT_BASE, r_vrow[8:4], r_col + 6'd1);
            end
          end
        end
        STALL: begin
          if (!w_fifo_full) begin
            r_state      <= CHAR;
            r_glyph_addr <= f_char_addr(TEXT_BASE, r_vrow[8:4], r_col);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift     <= 16'd0;
      r_bitcnt    <= 4'd0;
      r_fg        <= 4'd0;
      r_bg        <= 4'd0;
      r_valid     <= 1'b0;
      r_pix_color <= 4'd0;
    end else if (!active) begin
      r_pix_color <= 4'd0;
    end else if (pix_en) begin
      r_bitcnt <= r_bitcnt + 4'd1;
      if (r_bitcnt == 4'd0) begin
        if (!w_fifo_empty) begin
          r_shift     <= {w_head_word[14:0], 1'b0};
          r_fg        <= w_head[7:4];
          r_bg        <= w_head[3:0];
          r_valid     <= 1'b1;
          r_pix_color <= w_head_word[15] ? w_head[7:4] : w_head[3:0];
        end else begin
          r_shift     <= 16'd0;
          r_valid     <= 1'b0;
          r_pix_color <= 4'd0;
        end
      end else begin
        r_shift     <= {r_shift[14:0], 1'b0};
        r_pix_color <= !r_valid ? 4'd0 : (r_shift[15] ? r_fg : r_bg);
      end
    end
  end

`ifdef GLYPH_FETCH_UNDERRUN_EN
  logic r_underrun;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_underrun <= 1'b0;
    end else if (w_load && w_fifo_empty) begin
      r_underrun <= 1'b1;
    end
  end

  assign underrun = r_underrun;
`else
  assign underrun = 1'b0;
`endif

  assign glyph_addr = r_glyph_addr;
  assign pix_color  = r_pix_color;

endmodule

`default_nettype wire
